// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM state enum, the byte width and the rotating first-set search.
package uart_arb_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_t;

    // First set bit of req_vec scanning ptr+1, ptr+2, ... modulo num_req (num_req <= 8).
    function automatic int unsigned rr_first_set(input logic [7:0]  req_vec,
                                                 input int unsigned ptr,
                                                 input int unsigned num_req);
        int unsigned idx;
        int unsigned win;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = (ptr + k) % num_req;
            if (k <= num_req && !found && req_vec[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the message sources, the arbiter and the uart_tx serializer.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    import uart_arb_pkg::*;

    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_ready;
    logic [IdW-1:0]            grant_id;
    logic                      busy;
    logic                      timeout_pulse;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy, timeout_pulse
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy, timeout_pulse
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after rr_ptr_i, wrapping around.
module uart_tx_arbiter_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IdW     = 2
) (
    input  logic [NUM_REQ-1:0] req_vec_i,
    input  logic [IdW-1:0]     rr_ptr_i,
    output logic [IdW-1:0]     winner_o,
    output logic               any_req_o
);

    always_comb begin
        any_req_o = |req_vec_i;
        winner_o  = IdW'(rr_first_set(8'(req_vec_i), 32'(rr_ptr_i), NUM_REQ));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART byte transmitter among NUM_REQ sources.
// Optional grant watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_q;
    logic [IdW-1:0]      grant_id_q;
    logic [IdW-1:0]      rr_ptr_q;
    logic                tx_valid_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                timeout_q;

    logic [IdW-1:0]      winner;
    logic                any_req;
    logic                out_free;
    logic                accept;
    logic                acc_last;
    logic [BYTE_W-1:0]   acc_data;
    logic [NUM_REQ-1:0]  req_ready;

    uart_tx_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IdW     (IdW)
    ) u_picker (
        .req_vec_i (bus.req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        out_free  = !tx_valid_q || bus.tx_ready;
        acc_data  = bus.req_data[BYTE_W*grant_id_q +: BYTE_W];
        acc_last  = bus.req_last[grant_id_q];
        req_ready = '0;
        if (state_q == StGrant && out_free) begin
            req_ready[grant_id_q] = 1'b1;
        end
        accept = (state_q == StGrant) && out_free && bus.req_valid[grant_id_q];
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CntW-1:0] stall_cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_id_q  <= '0;
            rr_ptr_q    <= IdW'(NUM_REQ - 1);
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            timeout_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            // A new byte replaces the register even while the old one is being taken.
            if (accept) begin
                tx_data_q  <= acc_data;
                tx_valid_q <= 1'b1;
            end else if (bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            timeout_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_id_q <= winner;
                        rr_ptr_q   <= winner;
                        state_q    <= StGrant;
                    end
                end
                StGrant: begin
                    if (accept && acc_last) begin
                        state_q <= StIdle;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    if (accept) begin
                        stall_cnt_q <= '0;
                    end else if (!bus.req_valid[grant_id_q]) begin
                        // rr_ptr_q keeps the stalled index so it loses the next round.
                        if (stall_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                            timeout_q   <= 1'b1;
                            stall_cnt_q <= '0;
                            state_q     <= StIdle;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + CntW'(1);
                        end
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.busy          = (state_q != StIdle) || tx_valid_q;
    assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected bytes, a monitor pops on tx.
// Watchdog scenario is selected by UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [8:0] src_mem[NREQ][16];
    int         src_rd[NREQ];
    int         src_wr[NREQ];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Present the head of each source queue on the request lines.
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_data[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
                bus.req_last[i]        = src_mem[i][src_rd[i]][8];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
                bus.req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic load(input int src, input logic [7:0] b, input logic last);
        src_mem[src][src_wr[src]] = {last, b};
        src_wr[src]++;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic apply();
        drive();
        #1;
    endtask

    task automatic cyc();
        logic [NREQ-1:0] fire;
        @(negedge clk);
        fire = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (fire[i]) src_rd[i]++;
        end
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        bus.tx_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic drained(input string name);
        check(name, 32'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got=%0h want=none", bus.tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.tx_data !== mon_exp) begin
                    bad++;
                    $display("FAIL tx_byte: got=%0h want=%0h", bus.tx_data, mon_exp);
                end
            end
        end
    end

    initial begin
        int n;

        // Reset values
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        bus.tx_ready = 1'b1;
        drive();
        #12;
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_timeout", 32'(bus.timeout_pulse), 0);

        // Single requester, 3-byte message, latency and busy
        do_reset();
        load(1, 8'h4D, 1'b0); load(1, 8'h4F, 1'b0); load(1, 8'h44, 1'b1);
        expect_byte(8'h4D); expect_byte(8'h4F); expect_byte(8'h44);
        apply();
        check("t1_c0_no_ready", 32'(bus.req_ready), 0);
        check("t1_c0_busy", 32'(bus.busy), 0);
        cyc();
        check("t1_c1_grant", 32'(bus.grant_id), 1);
        check("t1_c1_ready", 32'(bus.req_ready), 32'h2);
        check("t1_c1_tx_valid", 32'(bus.tx_valid), 0);
        cyc();
        check("t1_c2_tx_valid", 32'(bus.tx_valid), 1);
        check("t1_c2_tx_data", 32'(bus.tx_data), 32'h4D);
        cyc();
        check("t1_c3_tx_data", 32'(bus.tx_data), 32'h4F);
        cyc();
        check("t1_c4_tx_data", 32'(bus.tx_data), 32'h44);
        check("t1_c4_busy", 32'(bus.busy), 1);
        cyc();
        check("t1_c5_busy", 32'(bus.busy), 0);
        check("t1_c5_tx_valid", 32'(bus.tx_valid), 0);
        drained("t1_drained");

        // Requesters 0 and 2 together: whole messages, 0 first
        do_reset();
        load(0, 8'h10, 1'b0); load(0, 8'h11, 1'b1);
        load(2, 8'h30, 1'b0); load(2, 8'h31, 1'b1);
        expect_byte(8'h10); expect_byte(8'h11); expect_byte(8'h30); expect_byte(8'h31);
        apply();
        cyc();
        check("t2_grant_first", 32'(bus.grant_id), 0);
        cyc();
        cyc();
        cyc();
        check("t2_grant_second", 32'(bus.grant_id), 2);
        check("t2_ready_second", 32'(bus.req_ready), 32'h4);
        repeat (4) cyc();
        drained("t2_drained");

        // Round-robin fairness with 1-byte messages
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                load(i, 8'(16 * i + k), 1'b1);
                expect_byte(8'(16 * i + k));
            end
        end
        apply();
        repeat (24) cyc();
        drained("t3_drained");

        // Backpressure mid-message
        do_reset();
        load(0, 8'h50, 1'b0); load(0, 8'h51, 1'b0); load(0, 8'h52, 1'b0); load(0, 8'h53, 1'b1);
        expect_byte(8'h50); expect_byte(8'h51); expect_byte(8'h52); expect_byte(8'h53);
        apply();
        repeat (3) cyc();
        bus.tx_ready = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            check("t4_hold_valid", 32'(bus.tx_valid), 1);
            check("t4_hold_data", 32'(bus.tx_data), 32'h51);
            check("t4_hold_ready", 32'(bus.req_ready), 0);
            cyc();
        end
        bus.tx_ready = 1'b1;
        #1;
        repeat (6) cyc();
        drained("t4_drained");

        // Asynchronous reset mid-message, partial message dropped
        do_reset();
        for (int b = 0; b < 5; b++) load(0, 8'(8'h60 + b), (b == 4));
        apply();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        check("t5_rst_tx_valid", 32'(bus.tx_valid), 0);
        check("t5_rst_grant", 32'(bus.grant_id), 0);
        check("t5_rst_busy", 32'(bus.busy), 0);
        do_reset();
        load(0, 8'h70, 1'b0); load(0, 8'h71, 1'b1);
        expect_byte(8'h70); expect_byte(8'h71);
        apply();
        check("t5_c0_no_ready", 32'(bus.req_ready), 0);
        cyc();
        check("t5_regrant", 32'(bus.grant_id), 0);
        check("t5_regrant_ready", 32'(bus.req_ready), 32'h1);
        repeat (4) cyc();
        drained("t5_drained");

        // Stalled grant: watchdog release, or indefinite wait without it
        do_reset();
        load(1, 8'h80, 1'b0);
        load(2, 8'h90, 1'b1);
        expect_byte(8'h80);
        apply();
        cyc();
        check("t6_grant_first", 32'(bus.grant_id), 1);
        cyc();
`ifdef UART_ARB_TIMEOUT_EN
        expect_byte(8'h90);
        n = 0;
        while (n < 40 && !bus.timeout_pulse) begin
            cyc();
            n++;
        end
        check("t6_timeout_cycle", 32'(n), 16);
        cyc();
        check("t6_pulse_width", 32'(bus.timeout_pulse), 0);
        check("t6_grant_next", 32'(bus.grant_id), 2);
        repeat (4) cyc();
`else
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.timeout_pulse) n++;
            cyc();
        end
        check("t6_no_timeout", 32'(n), 0);
        check("t6_grant_held", 32'(bus.grant_id), 1);
        check("t6_other_blocked", 32'(bus.req_ready), 32'h2);
        load(1, 8'h81, 1'b1);
        expect_byte(8'h81);
        expect_byte(8'h90);
        apply();
        repeat (6) cyc();
        check("t6_grant_after", 32'(bus.grant_id), 2);
`endif
        drained("t6_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
